// File: rtl/cic_comb_chain.sv
// ============================================================================
// cic_comb_chain : N-stage CIC comb (differentiator) chain with output
//                  reduction (round half-up + saturate, or truncate)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module cic_comb_chain #(
   parameter int INPUT_WIDTH  = 24,
   parameter int OUTPUT_WIDTH = 16,
   parameter int N_STAGES     = 4,
   parameter int DIFF_DELAY   = 1,
   parameter int ROUND        = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    strobe_in,
   input  logic [INPUT_WIDTH-1:0]  d_in,
   output logic                    strobe_out,
   output logic [OUTPUT_WIDTH-1:0] d_out
);

   localparam int c_shift = INPUT_WIDTH - OUTPUT_WIDTH;

   generate
      if (OUTPUT_WIDTH > INPUT_WIDTH || N_STAGES < 1 || N_STAGES > 8 ||
          (DIFF_DELAY != 1 && DIFF_DELAY != 2)) begin : g_param_err
         $error("cic_comb_chain: illegal parameter combination");
      end
   endgenerate

   generate
      for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
         logic [INPUT_WIDTH-1:0] w_x;
         logic                   w_vin;
         logic [INPUT_WIDTH-1:0] r_y;
         logic                   r_v;
         logic [INPUT_WIDTH-1:0] r_hist [DIFF_DELAY];

         if (k == 0) begin : g_first
            assign w_x   = d_in;
            assign w_vin = strobe_in;
         end else begin : g_chain
            assign w_x   = g_stage[k-1].r_y;
            assign w_vin = g_stage[k-1].r_v;
         end

         // History advances only on valid samples, so strobe gaps are transparent.
         always_ff @(posedge clock) begin
            if (reset) begin
               r_y <= '0;
               r_v <= 1'b0;
               for (int i = 0; i < DIFF_DELAY; i++) r_hist[i] <= '0;
            end else begin
               r_v <= w_vin;
               if (w_vin) begin
                  r_y       <= w_x - r_hist[DIFF_DELAY-1];
                  r_hist[0] <= w_x;
                  for (int i = 1; i < DIFF_DELAY; i++) r_hist[i] <= r_hist[i-1];
               end
            end
         end
      end
   endgenerate

   logic [INPUT_WIDTH-1:0]  w_y_last;
   logic                    w_v_last;
   logic [OUTPUT_WIDTH-1:0] w_red;

   assign w_y_last = g_stage[N_STAGES-1].r_y;
   assign w_v_last = g_stage[N_STAGES-1].r_v;

   generate
      if (ROUND != 0 && c_shift > 0) begin : g_round
         localparam logic [INPUT_WIDTH:0]    c_half = (INPUT_WIDTH+1)'(1) << (c_shift - 1);
         localparam logic [OUTPUT_WIDTH-1:0] c_max  = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
         logic [INPUT_WIDTH:0] w_sum;
         logic                 w_unused_lsb;

         assign w_sum        = {w_y_last[INPUT_WIDTH-1], w_y_last} + c_half;
         assign w_unused_lsb = ^w_sum[c_shift-1:0];
         // Only a positive input can carry into the sign bit; negatives never overflow.
         assign w_red = (!w_sum[INPUT_WIDTH] && w_sum[INPUT_WIDTH-1]) ? c_max
                                                                     : w_sum[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
      end else begin : g_trunc
         assign w_red = w_y_last[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
         if (c_shift > 0) begin : g_drop
            logic w_unused_lsb;
            assign w_unused_lsb = ^w_y_last[c_shift-1:0];
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         strobe_out <= 1'b0;
         d_out      <= '0;
      end else begin
         strobe_out <= w_v_last;
         if (w_v_last) d_out <= w_red;
      end
   end

endmodule

`default_nettype wire
